// File: rtl/uart_byte_receiver.sv
// +----------------------------------------------------------------------------+
// | Module   : uart_byte_receiver                                              |
// | Purpose  : 8N1 UART receiver, mid-bit sampling, framing-error detection.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_byte_receiver #(
    parameter int B       = 8,
    parameter int DIVISOR = 10416
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic         load,
    output logic [B-1:0] data,
    output logic         frame_error,
    output logic         busy
);

    localparam int HALF = DIVISOR / 2;
    localparam int CW   = $clog2(DIVISOR);
    localparam int IW   = (B > 1) ? $clog2(B) : 1;

    localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);
    localparam logic [CW-1:0] c_bit_last  = CW'(DIVISOR - 1);
    localparam logic [IW-1:0] c_idx_last  = IW'(B - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t        r_state, w_state_next;
    logic          r_s1, r_rx_s;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [IW-1:0] r_idx, w_idx_next;
    logic [B-1:0]  r_shift, w_shift_next;
    logic [B-1:0]  r_data, w_data_next;
    logic          r_load, w_load_next;
    logic          r_frame_error, w_frame_error_next;

    // Idle-high reset values keep a reset from looking like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1   <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_s1   <= rx;
            r_rx_s <= r_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_load        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_shift       <= w_shift_next;
            r_data        <= w_data_next;
            r_load        <= w_load_next;
            r_frame_error <= w_frame_error_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_idx_next         = r_idx;
        w_shift_next       = r_shift;
        w_data_next        = r_data;
        w_load_next        = 1'b0;
        w_frame_error_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_rx_s, r_shift[B-1:1]};
                    w_idx_next   = r_idx + 1'b1;
                    if (r_idx == c_idx_last) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // Returning to idle at the stop-bit centre leaves half a bit
                // to catch a start bit that follows immediately.
                if (r_cnt == c_bit_last) begin
                    w_cnt_next = '0;
                    if (r_rx_s) begin
                        w_data_next  = r_shift;
                        w_load_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_error_next = 1'b1;
                        w_state_next       = S_WAIT;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign load        = r_load;
    assign data        = r_data;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_receiver.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_byte_receiver                                           |
// | Purpose  : Self-checking bench for uart_byte_receiver at 16 cycles/bit.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_byte_receiver;

    localparam int NB  = 8;
    localparam int D   = 16;
    localparam int H   = D / 2;
    localparam int LAT = 2 + H + (NB + 1) * D + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx    = 1'b1;
    logic          load;
    logic          frame_error;
    logic          busy;
    logic [NB-1:0] data;

    int cyc     = 0;
    int n_cmp   = 0;
    int n_err   = 0;
    int both_hi = 0;

    int         ev_kind[$];
    int         ev_cyc[$];
    logic [7:0] ev_dat[$];
    int         exp_kind[$];
    int         exp_cyc[$];
    logic [7:0] exp_dat[$];
    int         ev_rd     = 0;
    int         ex_rd     = 0;
    logic [7:0] last_good = 8'h00;

    uart_byte_receiver #(
        .B       (NB),
        .DIVISOR (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .load        (load),
        .data        (data),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Event recorder: kind 0 = load, kind 1 = frame_error.
    always @(negedge clock) begin
        if (load) begin
            ev_kind.push_back(0);
            ev_cyc.push_back(cyc);
            ev_dat.push_back(data);
        end
        if (frame_error) begin
            ev_kind.push_back(1);
            ev_cyc.push_back(cyc);
            ev_dat.push_back(data);
        end
        if (load && frame_error) both_hi++;
    end

    // Level of the sender's line 'off' cycles after its start-bit fall,
    // for a frame sent at L cycles/bit and followed by idle-high.
    function automatic logic line_at(input logic [7:0] b, input int L,
                                     input logic stop_v, input int off);
        int idx;
        idx = off / L;
        if (idx == 0)       return 1'b0;
        else if (idx <= NB) return b[idx-1];
        else if (idx == NB + 1) return stop_v;
        else                return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with rx left at the stop level.
    task automatic send(input logic [7:0] b, input int L, input logic stop_v);
        int         fall;
        logic [7:0] got;
        logic       stop_seen;
        fall = cyc;
        for (int k = 0; k < NB; k++) got[k] = line_at(b, L, stop_v, H + (k + 1) * D);
        stop_seen = line_at(b, L, stop_v, H + (NB + 1) * D);
        exp_kind.push_back(stop_seen ? 0 : 1);
        exp_cyc.push_back(fall + LAT);
        exp_dat.push_back(got);
        if (stop_seen) last_good = got;
        rx = 1'b0;
        repeat (L) @(negedge clock);
        for (int k = 0; k < NB; k++) begin
            rx = b[k];
            repeat (L) @(negedge clock);
        end
        rx = stop_v;
        repeat (L) @(negedge clock);
    endtask

    task automatic check_events(input string tag);
        int n_obs;
        int n_exp;
        n_obs = ev_kind.size() - ev_rd;
        n_exp = exp_kind.size() - ex_rd;
        chk({tag, ".count"}, n_obs, n_exp);
        for (int i = 0; i < n_exp && i < n_obs; i++) begin
            chk({tag, ".kind"}, ev_kind[ev_rd+i], exp_kind[ex_rd+i]);
            chk({tag, ".cycle"}, ev_cyc[ev_rd+i], exp_cyc[ex_rd+i]);
            if (exp_kind[ex_rd+i] == 0) chk({tag, ".data"}, ev_dat[ev_rd+i], exp_dat[ex_rd+i]);
        end
        chk({tag, ".held"}, data, last_good);
        ev_rd = ev_kind.size();
        ex_rd = exp_kind.size();
    endtask

    logic [7:0] msg [7];
    logic [7:0] b0f;
    int         fall;

    initial begin
        msg = '{8'h24, 8'h47, 8'h50, 8'h5A, 8'h44, 8'h41, 8'h2C};
        b0f = 8'h0F;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset.data", data, 8'h00);
        chk("reset.load", load, 1'b0);
        chk("reset.frame_error", frame_error, 1'b0);
        chk("reset.busy", busy, 1'b0);
        repeat (5) @(negedge clock);

        send(8'h24, D, 1'b1);
        repeat (20) @(negedge clock);
        check_events("dollar");

        for (int i = 0; i < 7; i++) send(msg[i], D, 1'b1);
        repeat (20) @(negedge clock);
        check_events("gpzda");

        // Three-cycle low glitch is rejected at the start-bit centre.
        fall = cyc;
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (2) @(negedge clock);
        chk("glitch.busy_high", busy, 1'b1);
        repeat (7) @(negedge clock);
        chk("glitch.busy_low", busy, 1'b0);
        chk("glitch.elapsed", cyc - fall, 12);
        repeat (5) @(negedge clock);
        send(8'h55, D, 1'b1);
        repeat (20) @(negedge clock);
        check_events("glitch");

        // Zero stop bit followed by a held-low break.
        send(8'hA5, D, 1'b0);
        repeat (50) @(negedge clock);
        chk("break.busy", busy, 1'b1);
        repeat (50) @(negedge clock);
        check_events("break");
        rx = 1'b1;
        repeat (10) @(negedge clock);
        chk("break.idle", busy, 1'b0);
        send(8'h3A, D, 1'b1);
        repeat (20) @(negedge clock);
        check_events("after_break");

        // Reset in the middle of data bit 4 of 0x0F.
        rx = 1'b0;
        repeat (D) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            rx = b0f[k];
            repeat (D) @(negedge clock);
        end
        rx = b0f[4];
        repeat (D / 2) @(negedge clock);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_good = 8'h00;
        chk("abort.busy", busy, 1'b0);
        chk("abort.data", data, 8'h00);
        repeat (200) @(negedge clock);
        check_events("abort");
        send(8'hFF, D, 1'b1);
        repeat (20) @(negedge clock);
        check_events("after_abort");

        send(8'h00, D, 1'b1);
        repeat (20) @(negedge clock);
        send(8'hFF, D, 1'b1);
        repeat (20) @(negedge clock);
        check_events("edges");

        // One cycle/bit off at 16 cycles/bit is ~6% drift; the model
        // predicts from the sender's waveform where each sample lands.
        send(8'h31, 15, 1'b1);
        repeat (30) @(negedge clock);
        check_events("skew15");
        send(8'h31, 17, 1'b1);
        repeat (30) @(negedge clock);
        check_events("skew17");

        for (int i = 0; i < 8; i++) begin
            int g;
            g = $urandom_range(0, 12);
            repeat (g) @(negedge clock);
            send(8'($urandom_range(0, 255)), D, 1'b1);
        end
        repeat (20) @(negedge clock);
        check_events("random");

        chk("exclusive_pulses", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
